// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared types, encodings and output decode for the LC-3 control unit
package lc3_pkg;

    localparam int MEM_WAIT_DEF = 3;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    localparam logic [1:0] PCMUX_PC1   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic [1:0] ADDR2_ZERO   = 2'd0;
    localparam logic [1:0] ADDR2_SEXT6  = 2'd1;
    localparam logic [1:0] ADDR2_SEXT9  = 2'd2;
    localparam logic [1:0] ADDR2_SEXT11 = 2'd3;

    typedef enum logic [4:0] {
        S_HALTED, S_18, S_33, S_35, S_32,
        S_01, S_05, S_09, S_00, S_22, S_12,
        S_04, S_21, S_20, S_06, S_25, S_27,
        S_07, S_23, S_16, S_PAUSE1, S_PAUSE2
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       mem_oe, mem_we;
    } ctrl_t;

    // Memory states share the wait counter; only one is ever active at a time.
    function automatic logic is_mem(input state_t s);
        return (s == S_33) || (s == S_25) || (s == S_16);
    endfunction

    // Control word for a state; everything not listed stays 0 (MARMUX always 0).
    function automatic ctrl_t decode(input state_t s, input logic ir5);
        ctrl_t c;
        c = '0;
        case (s)
            S_18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_PC1; c.ld_pc = 1'b1; end
            S_33, S_25: begin c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
            S_35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            S_32: c.ld_ben = 1'b1;
            S_01, S_05, S_09: begin
                c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (s == S_01) ? ALUK_ADD : (s == S_05) ? ALUK_AND : ALUK_NOT;
            end
            S_22: begin c.addr2mux = ADDR2_SEXT9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; end
            S_12, S_20: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S_04: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
            S_21: begin c.addr2mux = ADDR2_SEXT11; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; end
            S_06, S_07: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_SEXT6;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S_27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            S_23: begin c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
            S_16: c.mem_we = 1'b1;
            S_PAUSE1: c.ld_led = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lc3_wait_ctr.sv
// rtl/lc3_wait_ctr.sv - memory strobe hold counter
module lc3_wait_ctr #(
    parameter int MEM_WAIT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    logic [CW-1:0] count_q;

    assign done_o = (count_q == CW'(MEM_WAIT - 1));

    // Count cycles spent in a memory state; stop at the terminal value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !done_o) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/lc3_isdu.sv
// rtl/lc3_isdu.sv - LC-3 instruction sequencing and decode FSM
module lc3_isdu
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output logic       GatePC, GateMDR, GateALU, GateMARMUX,
    output logic       SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN,
    output logic [1:0] PCMUX, ADDR2MUX, ALUK,
    output logic       Mem_OE, Mem_WE
);
    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   wait_done;

    lc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .clear_i  (is_mem(state_d) && (state_d != state_q)),
        .enable_i (is_mem(state_q)),
        .done_o   (wait_done)
    );

    // Next-state selection from current state, opcode and handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: if (Run) state_d = S_18;
            S_18:     state_d = S_33;
            S_33:     if (wait_done) state_d = S_35;
            S_35:     state_d = S_32;
            S_32: begin
                case (Opcode)
                    OP_ADD:   state_d = S_01;
                    OP_AND:   state_d = S_05;
                    OP_NOT:   state_d = S_09;
                    OP_BR:    state_d = S_00;
                    OP_JMP:   state_d = S_12;
                    OP_JSR:   state_d = S_04;
                    OP_LDR:   state_d = S_06;
                    OP_STR:   state_d = S_07;
                    OP_PAUSE: state_d = S_PAUSE1;
                    default:  state_d = S_18;
                endcase
            end
            S_00:     state_d = BEN ? S_22 : S_18;
            S_04:     state_d = IR_11 ? S_21 : S_20;
            S_06:     state_d = S_25;
            S_25:     if (wait_done) state_d = S_27;
            S_07:     state_d = S_23;
            S_23:     state_d = S_16;
            S_16:     if (wait_done) state_d = S_18;
            S_PAUSE1: if (Continue) state_d = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_d = S_18;
            S_01, S_05, S_09, S_22, S_12, S_21, S_20, S_27: state_d = S_18;
            default:  state_d = S_HALTED;
        endcase
    end

    // State register plus control word registered alongside it so outputs track the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_HALTED;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, IR_5);
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign MARMUX     = ctrl_q.marmux;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign MIO_EN     = ctrl_q.mio_en;
    assign PCMUX      = ctrl_q.pcmux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;
endmodule

// File: tb/tb_lc3_isdu.sv
// tb/tb_lc3_isdu.sv - scoreboard bench for the LC-3 control FSM
module tb_lc3_isdu;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       mem_oe, mem_we;
    } obs_t;

    localparam int H = 0, F18 = 1, M33 = 2, F35 = 3, D32 = 4, XADD = 5, XAND = 6, XNOT = 7;
    localparam int B00 = 8, B22 = 9, J12 = 10, J04 = 11, J21 = 12, J20 = 13;
    localparam int L06 = 14, L25 = 15, L27 = 16, T07 = 17, T23 = 18, T16 = 19, P1 = 20, P2 = 21;

    logic       Clk = 1'b0, Reset = 1'b0, Run = 1'b0, Continue = 1'b0;
    logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    obs_t       oa, ob;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t  exp_q[$];
    string name_q[$];

    always #5 Clk = ~Clk;

    lc3_isdu dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(oa.ld_mar), .LD_MDR(oa.ld_mdr), .LD_IR(oa.ld_ir), .LD_BEN(oa.ld_ben),
        .LD_CC(oa.ld_cc), .LD_REG(oa.ld_reg), .LD_PC(oa.ld_pc), .LD_LED(oa.ld_led),
        .GatePC(oa.gate_pc), .GateMDR(oa.gate_mdr), .GateALU(oa.gate_alu), .GateMARMUX(oa.gate_marmux),
        .SR2MUX(oa.sr2mux), .ADDR1MUX(oa.addr1mux), .MARMUX(oa.marmux), .DRMUX(oa.drmux),
        .SR1MUX(oa.sr1mux), .MIO_EN(oa.mio_en), .PCMUX(oa.pcmux), .ADDR2MUX(oa.addr2mux),
        .ALUK(oa.aluk), .Mem_OE(oa.mem_oe), .Mem_WE(oa.mem_we)
    );

    lc3_isdu #(.MEM_WAIT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(ob.ld_mar), .LD_MDR(ob.ld_mdr), .LD_IR(ob.ld_ir), .LD_BEN(ob.ld_ben),
        .LD_CC(ob.ld_cc), .LD_REG(ob.ld_reg), .LD_PC(ob.ld_pc), .LD_LED(ob.ld_led),
        .GatePC(ob.gate_pc), .GateMDR(ob.gate_mdr), .GateALU(ob.gate_alu), .GateMARMUX(ob.gate_marmux),
        .SR2MUX(ob.sr2mux), .ADDR1MUX(ob.addr1mux), .MARMUX(ob.marmux), .DRMUX(ob.drmux),
        .SR1MUX(ob.sr1mux), .MIO_EN(ob.mio_en), .PCMUX(ob.pcmux), .ADDR2MUX(ob.addr2mux),
        .ALUK(ob.aluk), .Mem_OE(ob.mem_oe), .Mem_WE(ob.mem_we)
    );

    function automatic obs_t ev(input int s, input logic ir5);
        obs_t e;
        e = '0;
        case (s)
            F18: begin e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; end
            M33, L25: begin e.mem_oe = 1; e.mio_en = 1; e.ld_mdr = 1; end
            F35: begin e.gate_mdr = 1; e.ld_ir = 1; end
            D32: e.ld_ben = 1;
            XADD, XAND, XNOT: begin
                e.sr1mux = 1; e.sr2mux = ir5; e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
                e.aluk = (s == XADD) ? 2'd0 : (s == XAND) ? 2'd1 : 2'd2;
            end
            B22: begin e.addr2mux = 2'd2; e.pcmux = 2'd2; e.ld_pc = 1; end
            J12, J20: begin e.sr1mux = 1; e.addr1mux = 1; e.pcmux = 2'd2; e.ld_pc = 1; end
            J04: begin e.gate_pc = 1; e.drmux = 1; e.ld_reg = 1; end
            J21: begin e.addr2mux = 2'd3; e.pcmux = 2'd2; e.ld_pc = 1; end
            L06, T07: begin e.sr1mux = 1; e.addr1mux = 1; e.addr2mux = 2'd1; e.gate_marmux = 1; e.ld_mar = 1; end
            L27: begin e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; end
            T23: begin e.aluk = 2'd3; e.gate_alu = 1; e.ld_mdr = 1; end
            T16: e.mem_we = 1;
            P1:  e.ld_led = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input int s, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ev(s, IR_5));
            name_q.push_back($sformatf("%s[%0d]", nm, i));
        end
    endtask

    task automatic push_fetch(input int mw);
        push(F18, 1, "s18");
        push(M33, mw, "s33");
        push(F35, 1, "s35");
        push(D32, 1, "s32");
    endtask

    task automatic drain(input bit use_b);
        obs_t e, got;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            @(posedge Clk);
            #1;
            Run = 1'b0;
            got = use_b ? ob : oa;
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, got, e);
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Run = 1'b0;
        Continue = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic start(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
        @(negedge Clk);
        Opcode = op;
        IR_5 = ir5;
        IR_11 = ir11;
        BEN = ben;
        Run = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Run = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_tests++;
        if (oa !== '0 || ob !== '0) begin
            n_fail++;
            $display("FAIL reset_run: got %h/%h expected 0", oa, ob);
        end
        @(negedge Clk);
        Run = 1'b0;
        Reset = 1'b1;
        push(H, 3, "halted");
        drain(1'b0);
    endtask

    task automatic test_alu();
        do_reset(); start(4'b0001, 1'b1, 1'b0, 1'b0);
        push_fetch(3); push(XADD, 1, "add"); push(F18, 1, "add_s18"); drain(1'b0);
        do_reset(); start(4'b0101, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(XAND, 1, "and"); push(F18, 1, "and_s18"); drain(1'b0);
        do_reset(); start(4'b1001, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(XNOT, 1, "not"); push(F18, 1, "not_s18"); drain(1'b0);
    endtask

    task automatic test_branch();
        do_reset(); start(4'b0000, 1'b0, 1'b0, 1'b1);
        push_fetch(3); push(B00, 1, "br_taken_s00"); push(B22, 1, "br_s22"); push(F18, 1, "br_s18"); drain(1'b0);
        do_reset(); start(4'b0000, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(B00, 1, "br_not_s00"); push(F18, 1, "br_not_s18"); drain(1'b0);
    endtask

    task automatic test_jumps();
        do_reset(); start(4'b1100, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(J12, 1, "jmp"); push(F18, 1, "jmp_s18"); drain(1'b0);
        do_reset(); start(4'b0100, 1'b0, 1'b1, 1'b0);
        push_fetch(3); push(J04, 1, "jsr_s04"); push(J21, 1, "jsr_s21"); push(F18, 1, "jsr_s18"); drain(1'b0);
        do_reset(); start(4'b0100, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(J04, 1, "jsrr_s04"); push(J20, 1, "jsrr_s20"); push(F18, 1, "jsrr_s18"); drain(1'b0);
    endtask

    task automatic test_mem_ops();
        do_reset(); start(4'b0110, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(L06, 1, "ldr_s06"); push(L25, 3, "ldr_s25"); push(L27, 1, "ldr_s27");
        push(F18, 1, "ldr_s18"); drain(1'b0);
        do_reset(); start(4'b0111, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(T07, 1, "str_s07"); push(T23, 1, "str_s23"); push(T16, 3, "str_s16");
        push(F18, 1, "str_s18"); drain(1'b0);
    endtask

    task automatic test_pause();
        do_reset(); start(4'b1101, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(P1, 5, "pause1"); drain(1'b0);
        Continue = 1'b1;
        push(P2, 4, "pause2"); drain(1'b0);
        Continue = 1'b0;
        push(F18, 1, "pause_s18"); push(M33, 1, "pause_s33"); drain(1'b0);
    endtask

    task automatic test_nop_and_run_ignored();
        do_reset(); start(4'b1111, 1'b0, 1'b0, 1'b0);
        push_fetch(3); push(F18, 1, "nop_s18"); drain(1'b0);
        Run = 1'b1;
        push(M33, 3, "run_ignored_s33"); push(F35, 1, "run_ignored_s35"); drain(1'b0);
    endtask

    task automatic test_async_reset();
        do_reset(); start(4'b0001, 1'b0, 1'b0, 1'b0);
        push(F18, 1, "ar_s18"); push(M33, 2, "ar_s33"); drain(1'b0);
        #2;
        Reset = 1'b0;
        #1;
        n_tests++;
        if (oa !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", oa);
        end
        push(H, 2, "ar_hold"); drain(1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        push(H, 2, "ar_idle"); drain(1'b0);
    endtask

    task automatic test_mem_wait1();
        do_reset(); start(4'b0001, 1'b1, 1'b0, 1'b0);
        push_fetch(1); push(XADD, 1, "mw1_add"); push(F18, 1, "mw1_s18"); drain(1'b1);
        do_reset(); start(4'b0111, 1'b0, 1'b0, 1'b0);
        push_fetch(1); push(T07, 1, "mw1_s07"); push(T23, 1, "mw1_s23"); push(T16, 1, "mw1_s16");
        push(F18, 1, "mw1_str_s18"); drain(1'b1);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jumps();
        test_mem_ops();
        test_pause();
        test_nop_and_run_ignored();
        test_async_reset();
        test_mem_wait1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_isdu.md
Name: lc3_isdu

Overview:
- Instruction sequencing and decode unit (control FSM) for the LC-3 datapath.
- Sits directly upstream of the datapath. It consumes IR opcode bits and BEN, and drives every load, gate and mux-select control input of the datapath plus the memory strobes.
- Moore machine with a programmable memory wait counter; supports ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE.

Parameters:
- MEM_WAIT, 3, cycles a memory read/write strobe is held (≥1).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start execution from HALTED.
- Continue  in  1  resume from PAUSE.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  immediate-mode bit.
- IR_11  in  1  JSR/JSRR select.
- BEN  in  1  registered branch enable from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus gates; at most one high per cycle.
- SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN  out  1 each  mux selects.
- PCMUX, ADDR2MUX, ALUK  out  2 each  mux/ALU selects.
- Mem_OE, Mem_WE  out  1 each  active-high memory read/write strobes.

Behaviour:
- Reset low (async): state=HALTED, wait counter=0. All outputs are Moore-decoded from state; every output is 0 in HALTED and every output defaults to 0 in any state that does not assert it.
- Select encodings:
  - PCMUX: 0=PC+1, 1=BUS, 2=adder.
  - ADDR2MUX: 0=zero, 1=sext6, 2=sext9, 3=sext11.
  - ADDR1MUX: 0=PC, 1=SR1.
  - SR1MUX: 0=IR[11:9], 1=IR[8:6].
  - DRMUX: 0=IR[11:9], 1=R7.
  - SR2MUX: 0=SR2, 1=sext5.
  - MIO_EN: 1 = MDR loads from memory.
  - ALUK: 0=ADD, 1=AND, 2=NOT, 3=PASSA.
  - MARMUX is held at 0.
- HALTED: go to S18 when Run=1; otherwise stay.
- Fetch sequence:
  - S18: GatePC, LD_MAR, PCMUX=0, LD_PC.
  - S33: Mem_OE, MIO_EN, LD_MDR, held MEM_WAIT cycles.
  - S35: GateMDR, LD_IR.
  - S32: LD_BEN, then decode on Opcode.
- Wait counter: cleared on entry to any memory state. Increments each cycle while in the state; the state exits when counter==MEM_WAIT-1. MEM_WAIT=1 gives a one-cycle state.
- Fetch latency: S18 entry to decode is MEM_WAIT+3 cycles (6 at default).
- ADD 0001 / AND 0101 / NOT 1001 → S01 / S05 / S09:
  - SR1MUX=1, SR2MUX=IR_5, ALUK = 0 / 1 / 2, GateALU, DRMUX=0, LD_REG, LD_CC.
  - Then S18.
- BR 0000 → S00:
  - If BEN=1 go to S22, else S18. BEN was latched in S32, so it is valid here.
  - S22: ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC; then S18.
- JMP 1100 → S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2, LD_PC; then S18.
- JSR 0100 → S04: GatePC, DRMUX=1, LD_REG (R7←PC). Then:
  - IR_11=1 → S21: ADDR1MUX=0, ADDR2MUX=3, PCMUX=2, LD_PC.
  - IR_11=0 → S20: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2, LD_PC.
  - Then S18.
- LDR 0110:
  - S06: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, GateMARMUX, LD_MAR.
  - S25: memory read, same as S33, MEM_WAIT cycles.
  - S27: GateMDR, DRMUX=0, LD_REG, LD_CC; then S18.
- STR 0111:
  - S07: same as S06.
  - S23: SR1MUX=0, ALUK=3, GateALU, MIO_EN=0, LD_MDR.
  - S16: Mem_WE held MEM_WAIT cycles; then S18.
- PAUSE 1101:
  - PAUSE1: LD_LED, held until Continue=1.
  - PAUSE2: wait for Continue=0, then S18.
- Any other opcode: return to S18 (NOP). No other state is reachable.
- Run while not HALTED and Continue outside PAUSE are ignored.
- Reset asserted mid-instruction (including mid-wait): immediate return to HALTED with all outputs 0, no partial strobe.

Decomposition:
- lc3_pkg holds:
  - the state_t enum;
  - opcode localparams;
  - ALUK, PCMUX and ADDR2MUX encodings;
  - the MEM_WAIT default.
- One sub-module, lc3_wait_ctr:
  - inputs: clear, enable;
  - output: done when count==MEM_WAIT-1;
  - async active-low reset.

Test Plan:
- Reset low, pulse Run → HALTED holds all outputs 0. After Run: S18 asserts GatePC/LD_MAR/LD_PC; Mem_OE high exactly 3 cycles; LD_IR on cycle 5; LD_BEN on cycle 6.
- Opcode=0001, IR_5=1 → in the decode+1 cycle: GateALU=1, SR2MUX=1, ALUK=0, LD_REG=1, LD_CC=1, SR1MUX=1; next cycle S18.
- Opcode=0000, BEN=1 then BEN=0 →
  - BEN=1: S22 with PCMUX=2, ADDR2MUX=2, LD_PC=1.
  - BEN=0: S18 directly, with no LD_PC from S22.
- Opcode=0111 → S07 LD_MAR with ADDR2MUX=1; S23 ALUK=3, MIO_EN=0; Mem_WE high 3 cycles; Mem_OE never high during execute.
- Opcode=1101 → LD_LED stays high while Continue=0. Continue=1 for 4 cycles goes to PAUSE2; Continue drop goes to S18.
- Reset dropped on the 2nd Mem_OE cycle → outputs all 0 asynchronously. Rerun with MEM_WAIT=1: Mem_OE lasts one cycle.
